chip8_lfsr_rng: RTL
===================

# chip8_lfsr_rng

Parametrised Galois-LFSR random number generator for the Chip8 CPU, the successor to the fixed 16-bit free-running generator. Adds configurable width and taps, seed loading, zero-lock recovery, a step enable, and a request/valid handshake that serves masked random bytes directly to the CXNN (`Vx = rand & NN`) execute path. Sits beside the CPU execute FSM on `cpu_clk`.

## Interface
- `WIDTH`, 16 — LFSR state width; legal range 8..32.
- `TAPS`, 16'hB400 — Galois feedback mask, WIDTH bits; must be maximal-length for WIDTH.
- `DEFAULT_SEED`, 16'hACE1 — reset and recovery value; must be nonzero.
- `MIX_STEPS`, 4 — forced LFSR advances per request; must be ≥ 1.
- `cpu_clk` input 1 — the single clock.
- `reset` input 1 — synchronous, active-high.
- `step_en` input 1 — free-running advance enable while not mixing.
- `seed_load` input 1 — load `seed` this cycle.
- `seed` input WIDTH — seed value.
- `req` input 1 — request a masked random byte.
- `mask` input 8 — NN byte, captured on request acceptance.
- `entropy_in` input 1 — entropy bit; present only with `CHIP8_RNG_ENTROPY_EN`.
- `rand_num` output WIDTH — current LFSR state.
- `rand_byte` output 8 — masked result.
- `rand_valid` output 1 — one-cycle pulse; `rand_byte` is valid.
- `busy` output 1 — a request is in flight.

## Operation
- Advance: if `state[0]` is 1, next = (state >> 1) ^ TAPS; else next = state >> 1.
- The LFSR advances on an edge when the FSM is in MIX, or when `step_en` is high in IDLE or OUT.
- Priority for the next state, highest first:
  - `reset` loads DEFAULT_SEED.
  - `seed_load` loads `seed`, or DEFAULT_SEED if `seed` is 0.
  - Advance.
  - Hold.
- Zero-lock: an advance result of 0 is replaced by DEFAULT_SEED. The state is never 0.
- FSM states IDLE, MIX, OUT:
  - IDLE: `req` high → capture `mask`, load `cnt = MIX_STEPS`, go to MIX.
  - MIX: advance every edge and decrement `cnt`. When `cnt` is 1 on the edge, go to OUT.
  - OUT: `rand_byte <= state[7:0] & mask_q`, `rand_valid <= 1`, go to IDLE.
- `busy` is high in MIX and OUT.
- `req` in MIX or OUT is ignored and not queued. `req` is accepted in the cycle `rand_valid` is high, since the FSM is then IDLE.
- `seed_load` during MIX replaces that cycle's advance. `cnt` still decrements, and the transaction completes normally.
- Mid-operation `reset` aborts the transaction. The FSM returns to IDLE and no valid pulse is issued.
- `mask` and `seed` are sampled only on their qualifying edges.

## Timing
- Reset values:
  - `rand_num` = DEFAULT_SEED.
  - `rand_byte` = 0.
  - `rand_valid` = 0.
  - `busy` = 0.
  - FSM = IDLE, `cnt` = 0.
- `rand_num` is registered and reflects the state one cycle after an advance or load.
- `req` sampled at edge k:
  - `busy` is high from k+1.
  - Advances occur at edges k+1..k+MIX_STEPS.
  - `rand_valid` and `rand_byte` update at edge k+MIX_STEPS+1, so latency is MIX_STEPS+1 cycles.
  - `busy` falls at the same edge.
- `rand_byte` holds its value until the next OUT state.
- `cnt` width is $clog2(MIX_STEPS+1).

## Configuration
- `CHIP8_RNG_ENTROPY_EN` defined:
  - The `entropy_in` port exists.
  - Each advance XORs `entropy_in` into bit WIDTH-1 of the next state, before the zero-lock check.
  - Intended source is keypad or timer activity.
- Undefined: no port; purely deterministic sequence.

## Structure
- `chip8_rng_pkg` holds:
  - the FSM state enum (`RNG_IDLE`, `RNG_MIX`, `RNG_OUT`);
  - tap constants for maximal-length LFSRs: `RNG_TAPS_8` = 8'hB8, `RNG_TAPS_16` = 16'hB400, `RNG_TAPS_32` = 32'h80200003;
  - `RNG_DEFAULT_SEED_16` = 16'hACE1.
- Sub-module `chip8_lfsr_step`: a combinational one-step Galois advance including zero-lock, parametrised by WIDTH/TAPS. The top level instantiates it once.

## Test plan
- Reset, then idle with `step_en`=0 → `rand_num`=16'hACE1, `busy`=0, `rand_valid`=0 for all cycles.
- `step_en`=1 for two cycles from 16'hACE1 → `rand_num` 16'hE270, then 16'h7138. Free-run 65535 advances → `rand_num` returns to 16'hACE1 and never reaches 0.
- `seed_load` with `seed`=0 → `rand_num`=16'hACE1. `seed_load` with 16'h1234 while `step_en`=1 → `rand_num`=16'h1234, i.e. load beats advance.
- MIX_STEPS=2, state 16'hACE1, `step_en`=0, `req` with `mask`=8'h0F at edge k:
  - `busy` high at edges k+1..k+2;
  - `rand_valid` pulses after edge k+3 with `rand_byte`=8'h08 (state 16'h7138);
  - a second `req` during `busy` is ignored.
- `reset` asserted during MIX → no `rand_valid`, `busy`=0, `rand_num`=16'hACE1 on the next cycle. A `req` in the `rand_valid` cycle is accepted back-to-back.
- With `CHIP8_RNG_ENTROPY_EN`, `entropy_in`=1, one advance from 16'hACE1 → 16'h6270. With `entropy_in`=0 → 16'hE270.

Source files
------------

// File: rtl/chip8_lfsr_rng_pkg.sv
// Shared types and constants for the Chip8 Galois-LFSR random number generator.
package chip8_rng_pkg;

   typedef enum logic [1:0] {
      RNG_IDLE = 2'd0,
      RNG_MIX  = 2'd1,
      RNG_OUT  = 2'd2
   } rng_state_e;

   // Maximal-length Galois feedback masks
   localparam logic [7:0]  RNG_TAPS_8  = 8'hB8;
   localparam logic [15:0] RNG_TAPS_16 = 16'hB400;
   localparam logic [31:0] RNG_TAPS_32 = 32'h80200003;

   localparam logic [15:0] RNG_DEFAULT_SEED_16 = 16'hACE1;

endpackage

// File: rtl/chip8_lfsr_rng_if.sv
// Request/valid handshake between the CPU execute path and the LFSR RNG (CXNN).
interface chip8_lfsr_rng_if;

   logic       req;
   logic [7:0] mask;
   logic [7:0] rand_byte;
   logic       rand_valid;
   logic       busy;

   modport master (output req, output mask, input rand_byte, input rand_valid, input busy);
   modport slave  (input req, input mask, output rand_byte, output rand_valid, output busy);

endinterface

// File: rtl/chip8_lfsr_step.sv
// Combinational single-step Galois LFSR advance with entropy injection and zero-lock recovery.
module chip8_lfsr_step #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
   input  logic [WIDTH-1:0] state_i,
   input  logic             entropy_i,
   output logic [WIDTH-1:0] next_o
);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] raw;

   always_comb begin
      shifted = state_i >> 1;
      if (state_i[0]) begin
         shifted = shifted ^ TAPS;
      end
      raw = shifted ^ {entropy_i, {(WIDTH-1){1'b0}}};
      // An all-zero state would lock the LFSR forever
      next_o = (raw == '0) ? DEFAULT_SEED : raw;
   end

endmodule

// File: rtl/chip8_lfsr_rng.sv
// Chip8 LFSR RNG: free-running/step-enabled Galois LFSR serving masked bytes for CXNN.
// Optional feature: define CHIP8_RNG_ENTROPY_EN to add the entropy_in port.
module chip8_lfsr_rng
   import chip8_rng_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = RNG_TAPS_16,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = RNG_DEFAULT_SEED_16,
   parameter int               MIX_STEPS    = 4
) (
   input  logic             cpu_clk,
   input  logic             reset,
   input  logic             step_en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
`ifdef CHIP8_RNG_ENTROPY_EN
   input  logic             entropy_in,
`endif
   output logic [WIDTH-1:0] rand_num,
   chip8_lfsr_rng_if.slave  bus
);

   localparam int CNT_W = $clog2(MIX_STEPS + 1);

   localparam logic [1:0] S_IDLE = 2'(RNG_IDLE);
   localparam logic [1:0] S_MIX  = 2'(RNG_MIX);
   localparam logic [1:0] S_OUT  = 2'(RNG_OUT);

   logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       mask_q, mask_d;
   logic [7:0]       byte_q, byte_d;
   logic             valid_q, valid_d;
   logic             advance;
   logic             entropy;

`ifdef CHIP8_RNG_ENTROPY_EN
   assign entropy = entropy_in;
`else
   assign entropy = 1'b0;
`endif

   chip8_lfsr_step #(
      .WIDTH        (WIDTH),
      .TAPS         (TAPS),
      .DEFAULT_SEED (DEFAULT_SEED)
   ) u_step (
      .state_i   (lfsr_q),
      .entropy_i (entropy),
      .next_o    (lfsr_step)
   );

   assign advance = (state_q == S_MIX) || step_en;

   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_load) begin
         lfsr_d = (seed == '0) ? DEFAULT_SEED : seed;
      end else if (advance) begin
         lfsr_d = lfsr_step;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               mask_d  = bus.mask;
               cnt_d   = CNT_W'(MIX_STEPS);
               state_d = S_MIX;
            end
         end
         S_MIX: begin
            // A seed load in MIX still consumes a mix step
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            byte_d  = lfsr_q[7:0] & mask_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         lfsr_q  <= DEFAULT_SEED;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mask_q  <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         lfsr_q  <= lfsr_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
      end
   end

   assign rand_num       = lfsr_q;
   assign bus.rand_byte  = byte_q;
   assign bus.rand_valid = valid_q;
   assign bus.busy       = (state_q != S_IDLE);

endmodule
